branch_target_calculator: RTL and testbench
===========================================

BRANCH_TARGET_CALCULATOR -- requirements
Module: branch_target_calculator

Interface
REQ-001 Parameter PC_W, default 8, width of program counter and branch target.
REQ-002 Parameter IMM_W, default 16, width of the signed branch immediate.
REQ-003 Parameter IMM_SHIFT, default 0, left shift applied to the sign-extended immediate before the add (0 = byte offset).
REQ-004 Clocking: one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  qualifies immediate and program_counter this cycle.
REQ-008 immediate  input  IMM_W  two's-complement branch offset.
REQ-009 program_counter  input  PC_W  unsigned current PC.
REQ-010 BT  output  PC_W  branch target, registered.
REQ-011 out_valid  output  1  BT and range_err hold a new result.
REQ-012 range_err  output  1  full-precision target fell outside [0, 2^PC_W-1].

Function
REQ-013 Offset is immediate sign-extended to PC_W+IMM_W+IMM_SHIFT+1 bits, then shifted left by IMM_SHIFT.
REQ-014 Full sum is zero-extended program_counter plus the offset, computed signed at that width with no overflow loss.
REQ-015 BT is the low PC_W bits of the full sum (modulo 2^PC_W wrap-around).
REQ-016 range_err is 1 when the full sum is negative or greater than 2^PC_W-1; otherwise 0.
REQ-017 Latency exactly one cycle: inputs sampled on a rising clk edge with in_valid=1 appear on BT/range_err after that edge, with out_valid=1.
REQ-018 When in_valid=0 at an edge, out_valid goes 0 and BT/range_err hold their previous values.
REQ-019 Back-to-back in_valid accepted every cycle; no backpressure, no stall.
REQ-020 Immediate 0 yields BT = program_counter, range_err=0.
REQ-021 Most-negative immediate (only MSB set) treated as -2^(IMM_W-1); most-positive as 2^(IMM_W-1)-1.
REQ-022 Outputs depend only on registered state; no combinational input-to-output path.

Reset
REQ-023 While rst_n=0: BT=0, out_valid=0, range_err=0, applied asynchronously.
REQ-024 Reset asserted mid-stream discards any in-flight result; the first valid result after rst_n rises appears one cycle after the first sampled in_valid.

Structure
REQ-025 Shared package holds default PC_W, IMM_W, IMM_SHIFT constants and a function computing the full-sum width.
REQ-026 One sub-module natural: bt_sign_extend (combinational sign-extend and shift of immediate); adder, range check and output register in the top.

Verification (PC_W=8, IMM_W=16, IMM_SHIFT=0)
REQ-027 PC=0x00, imm=0x1234, in_valid=1 -> next cycle BT=0x34, range_err=1, out_valid=1.
REQ-028 PC=0x04, imm=0xFFFF -> BT=0x03, range_err=0.
REQ-029 PC=0x08, imm=0x7FFF -> BT=0x07, range_err=1.
REQ-030 PC=0x0C, imm=0x0000 -> BT=0x0C, range_err=0; PC=0x10, imm=0x8000 -> BT=0x10, range_err=1.
REQ-031 PC=0xFF, imm=0x0001 -> BT=0x00, range_err=1; PC=0x00, imm=0xFFFF -> BT=0xFF, range_err=1.
REQ-032 Assert rst_n=0 between two valid inputs -> BT=0, out_valid=0 immediately; in_valid=0 cycle -> out_valid=0, BT held.

Source files
------------

// File: rtl/branch_target_calculator_pkg.sv
// ---------------------------------------------------------------------------
// branch_target_calculator_pkg
// Shared constants and helpers for the branch target calculator.
//   PC_W_DEFAULT      : default program counter / branch target width
//   IMM_W_DEFAULT     : default signed immediate width
//   IMM_SHIFT_DEFAULT : default left shift of the immediate (0 = byte offset)
//   full_sum_width()  : width that holds PC + shifted offset with no loss
// ---------------------------------------------------------------------------
package branch_target_calculator_pkg;

    localparam int PC_W_DEFAULT      = 8;
    localparam int IMM_W_DEFAULT     = 16;
    localparam int IMM_SHIFT_DEFAULT = 0;

    // One extra bit above PC + shifted immediate keeps the sign of the sum
    // even when a large positive offset is added to the largest PC.
    function automatic int full_sum_width(input int pc_w, input int imm_w,
                                          input int imm_shift);
        return pc_w + imm_w + imm_shift + 1;
    endfunction

endpackage

// File: rtl/branch_target_calculator_if.sv
// ---------------------------------------------------------------------------
// branch_target_calculator_if
// Request/result bundle of the branch target calculator.
//   in_valid, immediate, program_counter : request (master -> slave)
//   BT, out_valid, range_err             : registered result (slave -> master)
//
// Handshake: in_valid qualifies immediate/program_counter in the cycle it is
// high. There is no ready signal: the slave accepts every cycle, so a request
// is transferred on every rising edge where in_valid=1. out_valid marks the
// single cycle in which BT/range_err carry the result of that request.
// ---------------------------------------------------------------------------
interface branch_target_calculator_if
    import branch_target_calculator_pkg::*;
#(
    parameter int PC_W  = PC_W_DEFAULT,
    parameter int IMM_W = IMM_W_DEFAULT
) ();

    logic             in_valid;
    logic [IMM_W-1:0] immediate;
    logic [PC_W-1:0]  program_counter;
    logic [PC_W-1:0]  BT;
    logic             out_valid;
    logic             range_err;

    modport master (
        output in_valid, immediate, program_counter,
        input  BT, out_valid, range_err
    );

    modport slave (
        input  in_valid, immediate, program_counter,
        output BT, out_valid, range_err
    );

endinterface

// File: rtl/branch_target_calculator_sign_extend.sv
// ---------------------------------------------------------------------------
// bt_sign_extend
// Combinational sign extension of the branch immediate to the full-sum width,
// followed by a left shift of IMM_SHIFT bits.
//   immediate : IMM_W-bit two's-complement offset (input)
//   offset    : SUM_W-bit signed, shifted offset (output)
// ---------------------------------------------------------------------------
module bt_sign_extend #(
    parameter int IMM_W     = 16,
    parameter int SUM_W     = 25,
    parameter int IMM_SHIFT = 0
) (
    input  logic [IMM_W-1:0]        immediate,
    output logic signed [SUM_W-1:0] offset
);

    logic signed [SUM_W-1:0] extended;

    assign extended = {{(SUM_W-IMM_W){immediate[IMM_W-1]}}, immediate};

    // SUM_W already reserves IMM_SHIFT bits of headroom, so no bits are lost.
    assign offset = extended <<< IMM_SHIFT;

endmodule

// File: rtl/branch_target_calculator.sv
// ---------------------------------------------------------------------------
// branch_target_calculator
// Computes BT = program_counter + (sign-extended immediate << IMM_SHIFT),
// wrapped to PC_W bits, and flags range_err when the exact sum falls outside
// [0, 2^PC_W-1]. One-cycle latency, a new request may arrive every cycle.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears BT, out_valid, range_err)
//   bus   : branch_target_calculator_if.slave (request in, result out)
// ---------------------------------------------------------------------------
module branch_target_calculator
    import branch_target_calculator_pkg::*;
#(
    parameter int PC_W      = PC_W_DEFAULT,
    parameter int IMM_W     = IMM_W_DEFAULT,
    parameter int IMM_SHIFT = IMM_SHIFT_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    branch_target_calculator_if.slave   bus
);

    localparam int SUM_W = full_sum_width(PC_W, IMM_W, IMM_SHIFT);

    logic signed [SUM_W-1:0] offset;
    logic signed [SUM_W-1:0] full_sum;
    logic [PC_W-1:0]         bt_d;
    logic                    range_err_d;

    logic [PC_W-1:0]         bt_q;
    logic                    out_valid_q;
    logic                    range_err_q;

    bt_sign_extend #(
        .IMM_W     (IMM_W),
        .SUM_W     (SUM_W),
        .IMM_SHIFT (IMM_SHIFT)
    ) u_sign_extend (
        .immediate (bus.immediate),
        .offset    (offset)
    );

    // PC is unsigned: zero-extend it so it is never read as negative.
    assign full_sum = $signed({{(SUM_W-PC_W){1'b0}}, bus.program_counter}) + offset;

    assign bt_d = full_sum[PC_W-1:0];

    // Out of range when negative (sign bit) or any bit above the PC width set.
    assign range_err_d = full_sum[SUM_W-1] | (|full_sum[SUM_W-2:PC_W]);

    // Results only update on accepted requests; idle cycles hold them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bt_q        <= '0;
            out_valid_q <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                bt_q        <= bt_d;
                range_err_q <= range_err_d;
            end
        end
    end

    assign bus.BT        = bt_q;
    assign bus.out_valid = out_valid_q;
    assign bus.range_err = range_err_q;

endmodule

// File: tb/tb_branch_target_calculator.sv
// ---------------------------------------------------------------------------
// tb_branch_target_calculator
// Self-checking bench: spec vector table, randomized back-to-back requests,
// and hand-written reset / idle-hold sequences. Inputs are driven on the
// falling edge; outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_branch_target_calculator;

    localparam int PC_W      = 8;
    localparam int IMM_W     = 16;
    localparam int IMM_SHIFT = 0;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_target_calculator_if #(.PC_W(PC_W), .IMM_W(IMM_W)) bus ();

    branch_target_calculator #(
        .PC_W      (PC_W),
        .IMM_W     (IMM_W),
        .IMM_SHIFT (IMM_SHIFT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- scoreboard ----------------
    logic [PC_W:0] exp_q[$];   // {range_err, BT}
    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Independent reference: exact integer arithmetic, then wrap/range test.
    function automatic logic [PC_W:0] model(input logic [PC_W-1:0] pc,
                                            input logic [IMM_W-1:0] imm);
        longint off;
        longint full;
        logic [63:0] full_bits;
        logic err;
        off  = longint'($signed(imm)) * (longint'(1) << IMM_SHIFT);
        full = longint'({56'd0, pc}) + off;
        full_bits = full;
        err = (full < 0) || (full > ((longint'(1) << PC_W) - 1));
        return {err, full_bits[PC_W-1:0]};
    endfunction

    // Monitor: exactly one-cycle latency, so any pending expectation must be
    // answered at the very next rising edge.
    always begin
        @(posedge clk);
        #1;
        if (bus.out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_out_valid", {31'd0, bus.out_valid}, 32'd0);
            end else begin
                logic [PC_W:0] e;
                e = exp_q.pop_front();
                check("bt", {24'd0, bus.BT}, {24'd0, e[PC_W-1:0]});
                check("range_err", {31'd0, bus.range_err}, {31'd0, e[PC_W]});
            end
        end else if (exp_q.size() != 0) begin
            check("missing_out_valid", {31'd0, bus.out_valid}, 32'd1);
            void'(exp_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_valid(input logic [PC_W-1:0] pc, input logic [IMM_W-1:0] imm,
                               input logic [PC_W:0] expv);
        @(negedge clk);
        bus.in_valid        = 1'b1;
        bus.program_counter = pc;
        bus.immediate       = imm;
        exp_q.push_back(expv);
    endtask

    task automatic drive_idle();
        @(negedge clk);
        bus.in_valid        = 1'b0;
        bus.program_counter = PC_W'($urandom_range(0, (1 << PC_W) - 1));
        bus.immediate       = IMM_W'($urandom_range(0, (1 << IMM_W) - 1));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [PC_W-1:0]  pc;
        logic [IMM_W-1:0] imm;
        logic [PC_W-1:0]  bt;
        logic             err;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [PC_W:0] hold_exp;

        vecs[0] = '{8'h00, 16'h1234, 8'h34, 1'b1};
        vecs[1] = '{8'h04, 16'hFFFF, 8'h03, 1'b0};
        vecs[2] = '{8'h08, 16'h7FFF, 8'h07, 1'b1};
        vecs[3] = '{8'h0C, 16'h0000, 8'h0C, 1'b0};
        vecs[4] = '{8'h10, 16'h8000, 8'h10, 1'b1};
        vecs[5] = '{8'hFF, 16'h0001, 8'h00, 1'b1};
        vecs[6] = '{8'h00, 16'hFFFF, 8'hFF, 1'b1};
        vecs[7] = '{8'hFF, 16'h0000, 8'hFF, 1'b0};
        vecs[8] = '{8'h80, 16'hFF80, 8'h00, 1'b0};
        vecs[9] = '{8'h01, 16'h00FE, 8'hFF, 1'b0};

        bus.in_valid        = 1'b0;
        bus.program_counter = '0;
        bus.immediate       = '0;

        // Reset state while held in reset across clock edges.
        repeat (2) @(posedge clk);
        #1;
        check("reset_bt", {24'd0, bus.BT}, 32'd0);
        check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("reset_range_err", {31'd0, bus.range_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Spec table, back-to-back.
        for (int i = 0; i < 10; i++)
            drive_valid(vecs[i].pc, vecs[i].imm, {vecs[i].err, vecs[i].bt});
        drive_idle();

        // Randomized back-to-back stream checked against the model.
        for (int i = 0; i < 24; i++) begin
            logic [PC_W-1:0]  pc;
            logic [IMM_W-1:0] imm;
            pc  = PC_W'($urandom_range(0, (1 << PC_W) - 1));
            imm = IMM_W'($urandom_range(0, (1 << IMM_W) - 1));
            drive_valid(pc, imm, model(pc, imm));
        end
        drive_valid(8'hFF, 16'h7FFF, model(8'hFF, 16'h7FFF));
        drive_valid(8'h00, 16'h8000, model(8'h00, 16'h8000));
        drive_idle();

        // Idle cycle: out_valid drops, BT/range_err hold the last result.
        hold_exp = model(8'h04, 16'hFFFF);
        drive_valid(8'h04, 16'hFFFF, hold_exp);
        drive_idle();
        @(posedge clk);
        #2;
        check("hold_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("hold_bt", {24'd0, bus.BT}, {24'd0, hold_exp[PC_W-1:0]});
        check("hold_range_err", {31'd0, bus.range_err}, {31'd0, hold_exp[PC_W]});

        // Reset between two valid inputs: second result must be discarded.
        drive_valid(8'h20, 16'h0010, model(8'h20, 16'h0010));
        drive_valid(8'h30, 16'h1000, model(8'h30, 16'h1000));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_bt", {24'd0, bus.BT}, 32'd0);
        check("async_reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("async_reset_range_err", {31'd0, bus.range_err}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        @(posedge clk);
        #2;
        check("post_reset_idle_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("post_reset_idle_bt", {24'd0, bus.BT}, 32'd0);

        // First valid after reset appears one cycle later.
        drive_valid(8'hFE, 16'h0001, 9'h0FF);
        drive_idle();
        repeat (2) @(negedge clk);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
